// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board serial link (receiver and sender).
package link_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 8;
  localparam int DEFAULT_PAYLOAD_W    = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/link_frame_receiver.sv
// Serial frame receiver: start, LSB-first payload, even parity, stop; oversampled at CLKS_PER_BIT.
//
// state   | meaning
// IDLE    | line high, waiting for a falling edge
// START   | half a bit in, confirm start bit is still low
// DATA    | sample payload bits mid-bit, LSB first
// PARITY  | sample even-parity bit
// STOP    | sample stop bit, emit result pulses
// RECOVER | stop bit was low, wait for line to return high
module link_frame_receiver
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PAYLOAD_W    = DEFAULT_PAYLOAD_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [PAYLOAD_W-1:0] message_data,
  output logic                 message_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;

  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_W - 1);

  logic                 serial_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [PAYLOAD_W-1:0] shift_q;
  logic                 parity_q;
  logic                 parity_ok;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (serial_in),
    .q     (serial_s)
  );

  assign parity_ok = ((^shift_q) == parity_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      message_data  <= '0;
      message_valid <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      message_valid <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!serial_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_TC) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A start bit that is gone by mid-bit was a glitch
            if (!serial_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_TC) begin
            cnt              <= '0;
            shift_q[bit_idx] <= serial_s;
            if (bit_idx == LAST_IDX) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == BIT_TC) begin
            cnt      <= '0;
            parity_q <= serial_s;
            state    <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_TC) begin
            cnt <= '0;
            if (serial_s && parity_ok) begin
              message_data  <= shift_q;
              message_valid <= 1'b1;
            end
            parity_error  <= ~parity_ok;
            framing_error <= ~serial_s;
            if (serial_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RECOVER: begin
          if (serial_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_frame_receiver.sv
// Directed bench for link_frame_receiver: drives whole frames bit by bit and checks pulses/data.
module tb_link_frame_receiver;

  localparam int CPB = 8;
  localparam int PW  = 32;

  logic          clock;
  logic          reset;
  logic          serial_in;
  logic [PW-1:0] message_data;
  logic          message_valid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int valid_cnt = 0;
  int perr_cnt  = 0;
  int ferr_cnt  = 0;
  int cyc       = 0;
  int valid_cyc = 0;
  logic [PW-1:0] vdata[$];

  link_frame_receiver #(.CLKS_PER_BIT(CPB), .PAYLOAD_W(PW)) dut (
    .clock         (clock),
    .reset         (reset),
    .serial_in     (serial_in),
    .message_data  (message_data),
    .message_valid (message_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (message_valid) begin
      valid_cnt++;
      vdata.push_back(message_data);
      valid_cyc = cyc;
    end
    if (parity_error)  perr_cnt++;
    if (framing_error) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [PW-1:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < PW; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  int v0, p0, f0, c0, q0;
  logic [PW-1:0] abort_word;

  initial begin
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clock);

    // reset state
    check("rst_data",  message_data, 0);
    check("rst_valid", message_valid, 0);
    check("rst_perr",  parity_error, 0);
    check("rst_ferr",  framing_error, 0);
    check("rst_busy",  busy, 0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);

    // good frame, parity 0
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt; q0 = vdata.size();
    c0 = cyc;
    send_frame(32'hA5C3_0F1E, 1'b0, 1'b1);
    drive_bit(1'b1); drive_bit(1'b1);
    check("good_valid_cnt", valid_cnt - v0, 1);
    check("good_qdata", (vdata.size() > q0) ? vdata[q0] : 32'hX, 32'hA5C3_0F1E);
    check("good_data", message_data, 32'hA5C3_0F1E);
    check("good_perr", perr_cnt - p0, 0);
    check("good_ferr", ferr_cnt - f0, 0);
    check("good_latency", ((valid_cyc - c0) >= 279 && (valid_cyc - c0) <= 281), 1);
    check("good_busy_idle", busy, 0);

    // same payload, wrong parity
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(32'hA5C3_0F1E, 1'b1, 1'b1);
    drive_bit(1'b1); drive_bit(1'b1);
    check("par_perr", perr_cnt - p0, 1);
    check("par_valid", valid_cnt - v0, 0);
    check("par_ferr", ferr_cnt - f0, 0);
    check("par_data_kept", message_data, 32'hA5C3_0F1E);

    // stop bit low, line held low three bit times in total
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(32'h0000_0001, 1'b1, 1'b0);
    drive_bit(1'b0); drive_bit(1'b0);
    check("frm_ferr", ferr_cnt - f0, 1);
    check("frm_busy_low", busy, 1);
    drive_bit(1'b1); drive_bit(1'b1);
    check("frm_busy_idle", busy, 0);
    check("frm_perr", perr_cnt - p0, 0);
    check("frm_valid", valid_cnt - v0, 0);
    check("frm_data_kept", message_data, 32'hA5C3_0F1E);

    // two-cycle low glitch on idle line
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    serial_in = 1'b0;
    repeat (2) @(negedge clock);
    serial_in = 1'b1;
    @(negedge clock);
    check("glitch_start_busy", busy, 1);
    repeat (2 * CPB) @(negedge clock);
    check("glitch_back_idle", busy, 0);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);
    check("glitch_data_kept", message_data, 32'hA5C3_0F1E);

    // back-to-back frames
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt; q0 = vdata.size();
    send_frame(32'h1234_5678, 1'b1, 1'b1);
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b1);
    drive_bit(1'b1); drive_bit(1'b1);
    check("b2b_valid_cnt", valid_cnt - v0, 2);
    check("b2b_first", (vdata.size() > q0) ? vdata[q0] : 32'hX, 32'h1234_5678);
    check("b2b_second", (vdata.size() > q0 + 1) ? vdata[q0 + 1] : 32'hX, 32'hFFFF_FFFF);
    check("b2b_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);
    check("b2b_data", message_data, 32'hFFFF_FFFF);

    // reset in the middle of data bit 10, then a full frame
    abort_word = 32'hDEAD_BEEF;
    drive_bit(1'b0);
    for (int i = 0; i < 10; i++) drive_bit(abort_word[i]);
    serial_in = abort_word[10];
    repeat (CPB / 2) @(negedge clock);
    check("abort_busy_before", busy, 1);
    reset     = 1'b1;
    serial_in = 1'b1;
    @(negedge clock);
    check("abort_data", message_data, 0);
    check("abort_busy", busy, 0);
    check("abort_pulses", {message_valid, parity_error, framing_error}, 3'b000);
    reset = 1'b0;
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    repeat (2 * CPB) @(negedge clock);
    send_frame(32'hDEAD_BEEF, 1'b0, 1'b1);
    drive_bit(1'b1); drive_bit(1'b1);
    check("after_rst_valid", valid_cnt - v0, 1);
    check("after_rst_data", message_data, 32'hDEAD_BEEF);
    check("after_rst_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_frame_receiver.md
LINK_FRAME_RECEIVER -- requirements
Module: link_frame_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter PAYLOAD_W, default 32, payload bits per frame.
REQ-003 SHALL have port clock  input  1  the single system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port serial_in  input  1  asynchronous link line from the peer board (NEO_IN); idles high.
REQ-006 SHALL have port message_data  output  PAYLOAD_W  last correctly received payload.
REQ-007 SHALL have port message_valid  output  1  one-cycle pulse: new message_data available (new_message_received).
REQ-008 SHALL have port parity_error  output  1  one-cycle pulse: frame rejected, bad parity.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse: frame rejected, stop bit low.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 Frame format SHALL be: start bit 0, PAYLOAD_W data bits LSB first, one even-parity bit (XOR of payload), one stop bit 1.
REQ-012 serial_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value serial_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-014 IDLE: serial_s==0 -> START, bit counter cleared.
REQ-015 START: at counter==CLKS_PER_BIT/2-1, serial_s==0 -> DATA (counter, bit index cleared); serial_s==1 -> IDLE, no pulse (glitch rejection).
REQ-016 DATA: at counter==CLKS_PER_BIT-1, serial_s SHALL be stored at payload bit index, index incremented, counter cleared; after bit PAYLOAD_W-1 -> PARITY.
REQ-017 PARITY: at counter==CLKS_PER_BIT-1, sample parity bit -> STOP.
REQ-018 STOP: at counter==CLKS_PER_BIT-1, sample stop bit; stop==1 -> IDLE; stop==0 -> RECOVER.
REQ-019 RECOVER: remain until serial_s==1, then -> IDLE.
REQ-020 All outputs SHALL be registered; pulses assert the cycle after the STOP sample, for exactly one cycle.
REQ-021 Stop==1 and parity good: message_data updated and message_valid pulsed together.
REQ-022 Parity bad: parity_error pulsed; stop==0: framing_error pulsed; both may pulse in the same cycle; message_data SHALL be unchanged on any error.
REQ-023 message_data SHALL hold its value between frames.
REQ-024 A new start bit SHALL be accepted the cycle after returning to IDLE (back-to-back frames, no gap required).
REQ-025 Total latency, start-bit edge on serial_in to message_valid, SHALL be 2 + 1 + CLKS_PER_BIT/2 + (PAYLOAD_W+2)*CLKS_PER_BIT + 1 cycles (±1 for synchronizer phase).

Reset
REQ-026 On reset: state IDLE, counters 0, synchronizer flops 1, message_data 0, message_valid/parity_error/framing_error/busy 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes with the next start bit after reset deasserts.

Structure
REQ-028 Package link_pkg SHALL hold the rx_state_t enum, default CLKS_PER_BIT and PAYLOAD_W constants, shared with the link sender.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff (reset value parameter, here 1).

Verification
REQ-030 Frame payload 32'hA5C3_0F1E, parity 0, stop 1 -> one message_valid pulse, message_data==32'hA5C3_0F1E, no errors.
REQ-031 Same payload with parity 1 -> parity_error pulse only, message_data keeps prior value.
REQ-032 Payload 32'h0000_0001, parity 1, stop 0, then line high after 3 bit times -> framing_error pulse, busy high until line high, then IDLE.
REQ-033 Low glitch of 2 cycles on idle line -> START then IDLE, no pulses, message_data unchanged.
REQ-034 Two back-to-back frames 32'h1234_5678 then 32'hFFFF_FFFF -> two message_valid pulses, data in order, no errors.
REQ-035 reset asserted during DATA bit 10 -> outputs 0 next cycle, following full frame 32'hDEAD_BEEF received correctly.
